// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Final pipeline stage. It accepts execute results through a valid/ready
//   handshake and turns them into single-cycle register-file write pulses.
//   Load results are held in WAIT_LOAD until memory returns data. If no data
//   arrives within TIMEOUT cycles, the unit raises a sticky error flag and
//   drops the load.
//
// Parameters
//   TIMEOUT      maximum cycles spent in WAIT_LOAD (legal 2..255)
//
// Ports
//   clk, rst_n   clock (rising edge); asynchronous active-low reset
//   ex_valid     execute stage offers a result
//   ex_ready     unit can accept the offer this cycle (low only in WAIT_LOAD)
//   ex_regwrite  offered instruction writes a register
//   ex_is_load   offered instruction is a load; its data comes from memory
//   ex_rd        destination register index
//   ex_result    ALU result
//   mem_rvalid   load data valid
//   mem_rdata    load data
//   RegWrite     register-file write enable (one cycle per write)
//   Rd           register-file write index
//   Write_data   register-file write data
//   load_err     sticky load-timeout flag, cleared only by reset
//
// Optional feature (macro WB_BYPASS_EN)
//   Adds the Rs1/Rs2 inputs and a combinational forwarding path:
//   fwd_hitN/fwd_dataN report a match between RsN and the write in flight.
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_regwrite,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite,
  output logic [4:0]  Rd,
  output logic [31:0] Write_data,
  output logic        load_err
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]  Rs1,
  input  logic [4:0]  Rs2,
  output logic        fwd_hit1,
  output logic        fwd_hit2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_LOAD = 2'd2
  } state_t;

  // The counter compares against TIMEOUT-1, which is the final WAIT_LOAD cycle.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_regwrite;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;
  logic        r_load_err;
  logic [7:0]  r_cnt;
  logic        r_ld_regwrite;
  logic [4:0]  r_ld_rd;

  logic        w_xfer;

  assign ex_ready = (r_state != WAIT_LOAD);
  assign w_xfer   = ex_valid & ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_regwrite    <= 1'b0;
      r_rd          <= '0;
      r_wdata       <= '0;
      r_load_err    <= 1'b0;
      r_cnt         <= '0;
      r_ld_regwrite <= 1'b0;
      r_ld_rd       <= '0;
    end else begin
      // NOTE: all state updates are non-blocking, so every read in this block
      // sees the values from before the edge. The default below is safe
      // because any later assignment in the same pass overrides it.
      r_regwrite <= 1'b0;
      case (r_state)
        IDLE, WRITE: begin
          if (w_xfer) begin
            if (ex_is_load) begin
              r_ld_rd       <= ex_rd;
              r_ld_regwrite <= ex_regwrite;
              r_cnt         <= '0;
              r_state       <= WAIT_LOAD;
            end else if (ex_regwrite && (ex_rd != 5'd0)) begin
              r_rd       <= ex_rd;
              r_wdata    <= ex_result;
              r_regwrite <= 1'b1;
              r_state    <= WRITE;
            end else begin
              r_state <= IDLE;   // nothing to write (no regwrite, or rd = x0)
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_LOAD: begin
          // Load data takes priority over a timeout on the same edge.
          if (mem_rvalid) begin
            if (r_ld_regwrite && (r_ld_rd != 5'd0)) begin
              r_rd       <= r_ld_rd;
              r_wdata    <= mem_rdata;
              r_regwrite <= 1'b1;
              r_state    <= WRITE;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_cnt == LP_CNT_LAST) begin
            r_load_err <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign RegWrite   = r_regwrite;
  assign Rd         = r_rd;
  assign Write_data = r_wdata;
  assign load_err   = r_load_err;

`ifdef WB_BYPASS_EN
  // The Rd != 0 term is redundant because RegWrite never fires with Rd = 0.
  // It is kept so that the forwarding path is correct on its own.
  assign fwd_hit1  = r_regwrite & (Rs1 == r_rd) & (r_rd != 5'd0);
  assign fwd_hit2  = r_regwrite & (Rs2 == r_rd) & (r_rd != 5'd0);
  assign fwd_data1 = fwd_hit1 ? r_wdata : 32'd0;
  assign fwd_data2 = fwd_hit2 ? r_wdata : 32'd0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//   Self-checking bench for writeback_unit with TIMEOUT = 16.
//
//   A table of single-cycle ALU transfers is applied back to back. Hand-written
//   sequences then exercise loads, timeouts and reset. Each expected register
//   write is pushed to a scoreboard queue, tagged with the cycle in which it
//   must appear. A monitor checks every RegWrite pulse against that queue.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_regwrite = 1'b0, ex_is_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ex_ready, RegWrite, load_err;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
`ifdef WB_BYPASS_EN
  logic [4:0]  Rs1 = '0, Rs2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  writeback_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data), .load_err(load_err)
`ifdef WB_BYPASS_EN
    , .Rs1(Rs1), .Rs2(Rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;   // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t sb[$];

  // Push an expected write that must appear after the next rising edge.
  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd = rd; e.data = data; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && RegWrite) begin
      check("rd_nonzero_on_write", {31'd0, (Rd == 5'd0)}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", {31'd0, RegWrite}, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("sb_rd",   {27'd0, Rd}, {27'd0, e.rd});
        check("sb_data", Write_data, e.data);
        check("sb_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic rw,
                       input logic [4:0] rd, input logic [31:0] res);
    ex_valid = v; ex_is_load = ld; ex_regwrite = rw; ex_rd = rd; ex_result = res;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    check("rst_rd",       {27'd0, Rd}, 32'd0);
    check("rst_wdata",    Write_data, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        valid, is_load, regwrite;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        exp_we;
  } vec_t;
  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 1'b1};  // basic ALU write
    vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd0,  32'h0000_FFFF, 1'b0};  // rd = x0 discarded
    vecs[2] = '{1'b1, 1'b0, 1'b0, 5'd3,  32'h1111_1111, 1'b0};  // no regwrite
    vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd1,  32'h0BAD_F00D, 1'b1};  // back to back
    vecs[5] = '{1'b0, 1'b0, 1'b1, 5'd4,  32'h4444_4444, 1'b0};  // not valid
    vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd2,  32'h8000_0001, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0055, 1'b1};

    #3;
    do_reset();

    // The first vector is accepted on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].is_load, vecs[i].regwrite, vecs[i].rd, vecs[i].result);
      check("tbl_ex_ready", {31'd0, ex_ready}, 32'd1);
      if (vecs[i].exp_we) expect_write(vecs[i].rd, vecs[i].result);
      tick();
      check($sformatf("tbl_regwrite_%0d", i), {31'd0, RegWrite}, {31'd0, vecs[i].exp_we});
`ifdef WB_BYPASS_EN
      if (i == 7) begin
        Rs1 = 5'd9; Rs2 = 5'd0; #1;
        check("fwd_hit1",  {31'd0, fwd_hit1}, 32'd1);
        check("fwd_data1", fwd_data1, 32'h55);
        check("fwd_hit2",  {31'd0, fwd_hit2}, 32'd0);
        check("fwd_data2", fwd_data2, 32'd0);
      end
`endif
    end
    drive(0, 0, 0, 5'd0, 32'd0);
    tick();
    check("single_pulse", {31'd0, RegWrite}, 32'd0);
    check("hold_rd",      {27'd0, Rd}, 32'd9);
    check("hold_wdata",   Write_data, 32'h55);
`ifdef WB_BYPASS_EN
    check("fwd_hit1_idle", {31'd0, fwd_hit1}, 32'd0);
`endif

    // A stray mem_rvalid outside WAIT_LOAD must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    check("rvalid_idle_ignored", {31'd0, RegWrite}, 32'd0);
    mem_rvalid = 1'b0;

    // Load to rd 7 with data after 3 waiting cycles. A competing offer must
    // not be accepted while the unit waits.
    drive(1, 1, 1, 5'd7, 32'h0);
    tick();
    drive(1, 0, 1, 5'd12, 32'h1212_1212);
    for (int k = 0; k < 3; k++) begin
      check("ld_wait_ready_low", {31'd0, ex_ready}, 32'd0);
      tick();
      check("ld_wait_no_write", {31'd0, RegWrite}, 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    expect_write(5'd7, 32'hDEAD_BEEF);
    tick();
    mem_rvalid = 1'b0;
    drive(0, 0, 0, 5'd0, 32'd0);
    check("ld_regwrite", {31'd0, RegWrite}, 32'd1);
    check("ld_ready_back", {31'd0, ex_ready}, 32'd1);
    tick();
    check("ld_single_pulse", {31'd0, RegWrite}, 32'd0);

    // A load with regwrite = 0 completes without a write.
    drive(1, 1, 0, 5'd6, 32'h0);
    tick();
    drive(0, 0, 0, 5'd0, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    mem_rvalid = 1'b0;
    check("ld_norw_no_write", {31'd0, RegWrite}, 32'd0);
    check("ld_norw_ready",    {31'd0, ex_ready}, 32'd1);

    // Timeout: TIMEOUT edges in WAIT_LOAD without data.
    drive(1, 1, 1, 5'd8, 32'h0);
    tick();
    drive(0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < TO - 1; k++) tick();
    check("to_still_waiting", {31'd0, ex_ready}, 32'd0);
    check("to_err_not_yet",   {31'd0, load_err}, 32'd0);
    tick();
    check("to_load_err", {31'd0, load_err}, 32'd1);
    check("to_ready",    {31'd0, ex_ready}, 32'd1);
    check("to_no_write", {31'd0, RegWrite}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h8888_8888;  // late data is ignored
    tick();
    mem_rvalid = 1'b0;
    drive(1, 0, 1, 5'd10, 32'h0000_00AA);
    expect_write(5'd10, 32'h0000_00AA);
    tick();
    drive(0, 0, 0, 5'd0, 32'd0);
    check("to_err_sticky", {31'd0, load_err}, 32'd1);

    // Data arrives on the final (TIMEOUT-th) edge, so data wins over timeout.
    do_reset();
    drive(1, 1, 1, 5'd9, 32'h0);
    tick();
    drive(0, 0, 0, 5'd0, 32'd0);
    for (int k = 0; k < TO - 1; k++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
    expect_write(5'd9, 32'h0000_CAFE);
    tick();
    mem_rvalid = 1'b0;
    check("edge_regwrite", {31'd0, RegWrite}, 32'd1);
    check("edge_no_err",   {31'd0, load_err}, 32'd0);

    // Reset in WAIT_LOAD, then data after release: no write may follow.
    tick();
    drive(1, 1, 1, 5'd7, 32'h0);
    tick();
    drive(0, 0, 0, 5'd0, 32'd0);
    tick();
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("abort_no_write", {31'd0, RegWrite}, 32'd0);
      check("abort_rd",       {27'd0, Rd}, 32'd0);
      check("abort_wdata",    Write_data, 32'd0);
      check("abort_ready",    {31'd0, ex_ready}, 32'd1);
    end
    mem_rvalid = 1'b0;

    tick();
    tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
